// File: rtl/v1_pulse_gen.sv
// Synthetic detector pulse source: baseline plus linear-rise / exponential-decay pulse.
// Optional pile-up acceptance during DECAY is enabled with `define V1_PULSE_GEN_PILEUP_EN.
module v1_pulse_gen #(
  parameter int SIZE_ADC_DATA = 14,
  parameter int BASELINE      = 512,
  parameter int RISE_SHIFT    = 2,
  parameter int TAU_SHIFT     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [SIZE_ADC_DATA-1:0] amplitude,
  output logic [SIZE_ADC_DATA-1:0] adc_data,
  output logic                     busy,
  output logic                     pulse_done,
  output logic [7:0]               drop_count
);

  localparam int PW = SIZE_ADC_DATA + 1;
  localparam int CW = RISE_SHIFT + 1;
  localparam logic [CW-1:0]              RISE_LAST = CW'((1 << RISE_SHIFT) - 1);
  localparam logic [SIZE_ADC_DATA+1:0]   ADC_MAX   = (SIZE_ADC_DATA+2)'((1 << SIZE_ADC_DATA) - 1);
  localparam logic [SIZE_ADC_DATA+1:0]   BASE_W    = (SIZE_ADC_DATA+2)'(BASELINE);
  localparam logic [SIZE_ADC_DATA-1:0]   BASE_ADC  = SIZE_ADC_DATA'(BASELINE);

  typedef enum logic [1:0] {IDLE, RISE, DECAY} state_t;

  state_t                   state_q;
  logic [PW-1:0]            pv_q;
  logic [SIZE_ADC_DATA-1:0] amp_q;
  logic [SIZE_ADC_DATA-1:0] step_q;
  logic [CW-1:0]            rise_cnt_q;
`ifdef V1_PULSE_GEN_PILEUP_EN
  logic [PW-1:0]            base_q;
`endif

  logic [SIZE_ADC_DATA-1:0] amp_step;
  logic [PW-1:0]            decay_dec;
  logic [SIZE_ADC_DATA+1:0] adc_sum;
  logic [SIZE_ADC_DATA-1:0] adc_d;
  logic                     accept_pile;
  logic                     drop;

  function automatic logic [SIZE_ADC_DATA-1:0] sat_adc(input logic [SIZE_ADC_DATA+1:0] s);
    if (s > ADC_MAX) return {SIZE_ADC_DATA{1'b1}};
    return s[SIZE_ADC_DATA-1:0];
  endfunction

  function automatic logic [PW-1:0] sat_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[PW]) return {PW{1'b1}};
    return s[PW-1:0];
  endfunction

  always_comb begin
    amp_step  = amplitude >> RISE_SHIFT;
    decay_dec = pv_q >> TAU_SHIFT;
    adc_sum   = BASE_W + (SIZE_ADC_DATA+2)'(pv_q);
    adc_d     = sat_adc(adc_sum);
`ifdef V1_PULSE_GEN_PILEUP_EN
    accept_pile = start && (state_q == DECAY);
`else
    accept_pile = 1'b0;
`endif
    drop = start && (state_q != IDLE) && !accept_pile;
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pv_q       <= '0;
      amp_q      <= '0;
      step_q     <= '0;
      rise_cnt_q <= '0;
      adc_data   <= BASE_ADC;
      pulse_done <= 1'b0;
      drop_count <= '0;
`ifdef V1_PULSE_GEN_PILEUP_EN
      base_q     <= '0;
`endif
    end else begin
      adc_data   <= adc_d;
      pulse_done <= 1'b0;
      if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;

      case (state_q)
        IDLE: begin
          pv_q <= '0;
          if (start) begin
            amp_q      <= amplitude;
            step_q     <= amp_step;
            rise_cnt_q <= CW'(1);
`ifdef V1_PULSE_GEN_PILEUP_EN
            base_q     <= '0;
`endif
            if (RISE_SHIFT == 0) begin
              pv_q    <= PW'(amplitude);
              state_q <= DECAY;
            end else begin
              pv_q    <= PW'(amp_step);
              state_q <= RISE;
            end
          end
        end

        RISE: begin
          // Last rise step lands on the exact peak, discarding shift truncation.
          if (rise_cnt_q == RISE_LAST) begin
`ifdef V1_PULSE_GEN_PILEUP_EN
            pv_q <= sat_add(base_q, PW'(amp_q));
`else
            pv_q <= PW'(amp_q);
`endif
            state_q <= DECAY;
          end else begin
            pv_q       <= sat_add(pv_q, PW'(step_q));
            rise_cnt_q <= rise_cnt_q + CW'(1);
          end
        end

        DECAY: begin
          if (accept_pile) begin
`ifdef V1_PULSE_GEN_PILEUP_EN
            base_q     <= pv_q;
            amp_q      <= amplitude;
            step_q     <= amp_step;
            rise_cnt_q <= CW'(1);
            if (RISE_SHIFT == 0) begin
              pv_q <= sat_add(pv_q, PW'(amplitude));
            end else begin
              pv_q    <= sat_add(pv_q, PW'(amp_step));
              state_q <= RISE;
            end
`endif
          end else if (decay_dec == '0) begin
            pv_q       <= '0;
            state_q    <= IDLE;
            pulse_done <= 1'b1;
          end else begin
            pv_q <= pv_q - decay_dec;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
